// File: rtl/lv_pwm_fault_ctrl.sv
// LV-side PWM fault controller: blanks mismatch errors around PWM edges,
// sequences IDLE/RUN/FAULT/REARM, gates the PWM output and keeps sticky status.
module lv_pwm_fault_ctrl #(
  parameter int CLK_M     = 48,
  parameter int BLANK_CYC = 1 * CLK_M,
  parameter int REARM_CYC = 10 * CLK_M
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_pwm_en,
  input  logic       i_pwm_in,
  input  logic       i_mmerr,
  input  logic       i_dterr,
  input  logic       i_mmerr_mask,
  input  logic       i_dterr_mask,
  input  logic       i_fault_clr,
  output logic       o_pwm_out,
  output logic       o_fault_int,
  output logic       o_mmerr_sts,
  output logic       o_dterr_sts,
  output logic [1:0] o_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;
  localparam logic [1:0] S_REARM = 2'd3;

  localparam int BW = $clog2(BLANK_CYC + 1);
  localparam int RW = (REARM_CYC > 1) ? $clog2(REARM_CYC) : 1;

  logic [1:0]    state_q, state_d;
  logic          pwm_in_q;
  logic [BW-1:0] blank_cnt_q, blank_cnt_d;
  logic [RW-1:0] rearm_cnt_q, rearm_cnt_d;
  logic          mm_sts_q, mm_sts_d;
  logic          dt_sts_q, dt_sts_d;

  logic pwm_edge, blank_active, src_mm, src_dt, src_any;
  logic in_run, in_fault, in_rearm, mm_hit, dt_hit, hit, clr_eff;

  always_comb begin
    pwm_edge     = i_pwm_in ^ pwm_in_q;
    blank_active = (blank_cnt_q != '0);
    src_mm       = i_mmerr & ~i_mmerr_mask;
    src_dt       = i_dterr & ~i_dterr_mask;
    src_any      = src_mm | src_dt;
    in_run       = (state_q == S_RUN);
    in_fault     = (state_q == S_FAULT);
    in_rearm     = (state_q == S_REARM);
    mm_hit       = src_mm & ~blank_active & in_run;
    dt_hit       = src_dt & in_run;
    hit          = mm_hit | dt_hit;
    // A clear rejected because an error is still present leaves status untouched.
    clr_eff      = i_fault_clr & ~(in_fault & src_any);
  end

  always_comb begin
    blank_cnt_d = blank_cnt_q;
    if (pwm_edge) begin
      blank_cnt_d = BW'(BLANK_CYC);
    end else if (blank_active) begin
      blank_cnt_d = blank_cnt_q - BW'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    rearm_cnt_d = rearm_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_pwm_en) state_d = S_RUN;
      end
      S_RUN: begin
        if (hit) state_d = S_FAULT;
        else if (!i_pwm_en) state_d = S_IDLE;
      end
      S_FAULT: begin
        if (i_fault_clr && !src_any) begin
          state_d     = S_REARM;
          rearm_cnt_d = RW'(REARM_CYC - 1);
        end
      end
      S_REARM: begin
        // Errors during the hold bypass blanking and send the channel back to FAULT.
        if (src_any) begin
          state_d = S_FAULT;
        end else if (rearm_cnt_q == '0) begin
          state_d = i_pwm_en ? S_RUN : S_IDLE;
        end else begin
          rearm_cnt_d = rearm_cnt_q - RW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mm_sts_d = mm_hit | (in_rearm & src_mm) | (mm_sts_q & ~clr_eff);
    dt_sts_d = dt_hit | (in_rearm & src_dt) | (dt_sts_q & ~clr_eff);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      pwm_in_q    <= 1'b0;
      blank_cnt_q <= '0;
      rearm_cnt_q <= '0;
      mm_sts_q    <= 1'b0;
      dt_sts_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pwm_in_q    <= i_pwm_in;
      blank_cnt_q <= blank_cnt_d;
      rearm_cnt_q <= rearm_cnt_d;
      mm_sts_q    <= mm_sts_d;
      dt_sts_q    <= dt_sts_d;
    end
  end

  assign o_pwm_out   = i_pwm_in & in_run & ~hit;
  assign o_fault_int = mm_sts_q | dt_sts_q;
  assign o_mmerr_sts = mm_sts_q;
  assign o_dterr_sts = dt_sts_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_lv_pwm_fault_ctrl.sv
// Bench for lv_pwm_fault_ctrl: directed scenarios plus random traffic, all
// checked every cycle against a timestamp-based behavioural model.
module tb_lv_pwm_fault_ctrl;
  localparam int CLK_M     = 48;
  localparam int BLANK_CYC = 48;
  localparam int REARM_CYC = 480;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pwm_en = 1'b0, pwm_in = 1'b0, mmerr = 1'b0, dterr = 1'b0;
  logic mmerr_mask = 1'b0, dterr_mask = 1'b0, fault_clr = 1'b0;
  logic pwm_out, fault_int, mmerr_sts, dterr_sts;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: channel mode as a name, blanking from the time of the last edge,
  // hold timer as "cycles spent in re-arm so far".
  typedef enum int {M_IDLE = 0, M_RUN = 1, M_FAULT = 2, M_REARM = 3} mode_t;
  mode_t m_mode;
  int    cyc;
  int    m_last_edge;
  int    m_rearm_age;
  bit    m_prev_in, m_mm, m_dt;

  lv_pwm_fault_ctrl #(.CLK_M(CLK_M), .BLANK_CYC(BLANK_CYC), .REARM_CYC(REARM_CYC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pwm_en(pwm_en), .i_pwm_in(pwm_in),
    .i_mmerr(mmerr), .i_dterr(dterr), .i_mmerr_mask(mmerr_mask),
    .i_dterr_mask(dterr_mask), .i_fault_clr(fault_clr),
    .o_pwm_out(pwm_out), .o_fault_int(fault_int), .o_mmerr_sts(mmerr_sts),
    .o_dterr_sts(dterr_sts), .o_state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_mode      = M_IDLE;
    m_last_edge = -1000000;
    m_rearm_age = 0;
    m_prev_in   = 1'b0;
    m_mm        = 1'b0;
    m_dt        = 1'b0;
  endtask

  // One clock cycle: inputs were set after the previous edge; compare at negedge,
  // then advance the model on the rising edge.
  task automatic tick();
    bit edge_now, blanked, e_mm, e_dt, mm_hit, dt_hit, rej_clr, clr_ok, set_mm, set_dt;
    @(negedge clk);
    edge_now = (pwm_in != m_prev_in);
    blanked  = (cyc - m_last_edge >= 1) && (cyc - m_last_edge <= BLANK_CYC);
    e_mm     = mmerr && !mmerr_mask;
    e_dt     = dterr && !dterr_mask;
    mm_hit   = e_mm && !blanked && (m_mode == M_RUN);
    dt_hit   = e_dt && (m_mode == M_RUN);
    check("pwm_out", 32'(pwm_out), 32'(pwm_in && (m_mode == M_RUN) && !(mm_hit || dt_hit)));
    check("state", 32'(state), 32'(m_mode));
    check("mmerr_sts", 32'(mmerr_sts), 32'(m_mm));
    check("dterr_sts", 32'(dterr_sts), 32'(m_dt));
    check("fault_int", 32'(fault_int), 32'(m_mm || m_dt));
    @(posedge clk);
    rej_clr = (m_mode == M_FAULT) && (e_mm || e_dt);
    clr_ok  = fault_clr && !rej_clr;
    set_mm  = mm_hit || (m_mode == M_REARM && e_mm);
    set_dt  = dt_hit || (m_mode == M_REARM && e_dt);
    m_mm    = set_mm || (m_mm && !clr_ok);
    m_dt    = set_dt || (m_dt && !clr_ok);
    if (edge_now) m_last_edge = cyc;
    m_prev_in = pwm_in;
    case (m_mode)
      M_IDLE:  if (pwm_en) m_mode = M_RUN;
      M_RUN:   if (mm_hit || dt_hit) m_mode = M_FAULT; else if (!pwm_en) m_mode = M_IDLE;
      M_FAULT: if (fault_clr && !rej_clr) begin m_mode = M_REARM; m_rearm_age = 0; end
      default: begin
        if (e_mm || e_dt) m_mode = M_FAULT;
        else if (m_rearm_age == REARM_CYC - 1) m_mode = pwm_en ? M_RUN : M_IDLE;
        else m_rearm_age++;
      end
    endcase
    cyc++;
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pwm_out"}, 32'(pwm_out), 0);
    check({tag, "_fault_int"}, 32'(fault_int), 0);
    check({tag, "_mmerr_sts"}, 32'(mmerr_sts), 0);
    check({tag, "_dterr_sts"}, 32'(dterr_sts), 0);
    check({tag, "_state"}, 32'(state), 0);
  endtask

  initial begin
    int period, cnt, seg_err;
    cyc = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Enable and run a 100-cycle-period PWM with no errors.
    pwm_en = 1'b1;
    tick();
    check("en_to_run", 32'(state), 1);
    for (int k = 0; k < 300; k++) begin
      pwm_in = ((k % 100) < 50);
      tick();
    end

    // mmerr inside the blanking window is ignored.
    pwm_in = 1'b0; ticks(60);
    pwm_in = 1'b1; ticks(10);
    mmerr = 1'b1; tick(); mmerr = 1'b0;
    check("blanked_mm_state", 32'(state), 1);
    check("blanked_mm_sts", 32'(mmerr_sts), 0);

    // mmerr 60 cycles after an edge is accepted.
    pwm_in = 1'b0; ticks(60);
    pwm_in = 1'b1; ticks(60);
    mmerr = 1'b1; tick(); mmerr = 1'b0;
    check("mm_fault_state", 32'(state), 2);
    check("mm_fault_sts", 32'(mmerr_sts), 1);
    check("mm_fault_int", 32'(fault_int), 1);
    ticks(5);

    // Clear: exactly REARM_CYC cycles of forced-off hold, then RUN.
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    check("clr_state", 32'(state), 3);
    check("clr_sts", 32'(mmerr_sts), 0);
    ticks(REARM_CYC - 1);
    check("rearm_last", 32'(state), 3);
    tick();
    check("rearm_done", 32'(state), 1);

    // Masked dterr does nothing; unmasked dterr faults.
    dterr_mask = 1'b1; dterr = 1'b1; tick(); dterr = 1'b0;
    check("dt_masked_state", 32'(state), 1);
    dterr_mask = 1'b0; dterr = 1'b1; tick(); dterr = 1'b0;
    check("dt_fault_state", 32'(state), 2);
    check("dt_fault_dsts", 32'(dterr_sts), 1);
    check("dt_fault_msts", 32'(mmerr_sts), 0);

    // Clear blocked by a simultaneous error; then an error mid-rearm.
    fault_clr = 1'b1; dterr = 1'b1; tick(); fault_clr = 1'b0; dterr = 1'b0;
    check("blocked_clr_state", 32'(state), 2);
    check("blocked_clr_sts", 32'(dterr_sts), 1);
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    ticks(99);
    dterr = 1'b1; tick(); dterr = 1'b0;
    check("rearm_err_state", 32'(state), 2);
    check("rearm_err_sts", 32'(dterr_sts), 1);

    // Asynchronous reset in the middle of REARM.
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    ticks(200);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("midrst_hold");
    rst_n = 1'b1;
    tick();
    check("post_rst_run", 32'(state), 1);

    // Unmasking a persistent mmerr after blanking expires faults at once.
    pwm_in = 1'b1; ticks(BLANK_CYC + 5);
    mmerr_mask = 1'b1; mmerr = 1'b1; ticks(3);
    mmerr_mask = 1'b0; tick(); mmerr = 1'b0;
    check("unmask_fault", 32'(state), 2);
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    ticks(REARM_CYC + 2);

    // Random traffic in segments with varying masks and error rates.
    for (int seg = 0; seg < 30; seg++) begin
      mmerr_mask = 1'($urandom_range(0, 3) == 0);
      dterr_mask = 1'($urandom_range(0, 3) == 0);
      seg_err    = $urandom_range(0, 2);
      period     = $urandom_range(20, 120);
      cnt        = 0;
      for (int k = 0; k < 400; k++) begin
        if (++cnt >= period) begin pwm_in = ~pwm_in; cnt = 0; end
        if ($urandom_range(0, 399) == 0) pwm_en = ~pwm_en;
        if (seg_err != 0 && $urandom_range(0, 149) == 0) mmerr = 1'b1;
        else if ($urandom_range(0, 7) == 0) mmerr = 1'b0;
        dterr     = 1'(seg_err == 2 && $urandom_range(0, 199) == 0);
        fault_clr = 1'($urandom_range(0, 119) == 0);
        tick();
      end
      mmerr = 1'b0; dterr = 1'b0; fault_clr = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/lv_pwm_fault_ctrl.md
# lv_pwm_fault_ctrl

Low-voltage-side PWM fault controller. It sits between the PWM source and the gate-drive path, downstream of the LV PWM integrity checker that produces the mismatch (mmerr) and dead-time (dterr) error pulses. It sequences the PWM channel through idle, run, fault and re-arm states, blanks mismatch errors around PWM edges, gates the PWM output off on an accepted fault, and keeps sticky status bits plus an interrupt for the register bank.

## Interface
Parameters:
- CLK_M, 48, clock cycles per microsecond.
- BLANK_CYC, 1*CLK_M, mmerr blanking window after each i_pwm_in edge (cycles, ≥1).
- REARM_CYC, 10*CLK_M, forced-off hold time after a fault clear (cycles, ≥1).

Ports:
- i_clk, input, 1, clock.
- i_rst_n, input, 1, reset; asynchronous, active-low.
- i_pwm_en, input, 1, channel enable (register level).
- i_pwm_in, input, 1, raw PWM from the generator.
- i_mmerr, input, 1, mismatch error (level while the error persists).
- i_dterr, input, 1, dead-time error pulse (1 cycle).
- i_mmerr_mask, input, 1, 1 = ignore mmerr.
- i_dterr_mask, input, 1, 1 = ignore dterr.
- i_fault_clr, input, 1, fault clear pulse (write-1-to-clear strobe).
- o_pwm_out, output, 1, gated PWM to the gate driver.
- o_fault_int, output, 1, interrupt, level; high while any status bit is set.
- o_mmerr_sts, output, 1, sticky mismatch status.
- o_dterr_sts, output, 1, sticky dead-time status.
- o_state, output, 2, FSM state: 0 IDLE, 1 RUN, 2 FAULT, 3 REARM.

## Operation
- Reset values:
  - state = IDLE, all status bits = 0, counters = 0.
  - o_pwm_out = 0, o_fault_int = 0.
- Accepted errors:
  - mm_hit = i_mmerr & ~i_mmerr_mask & ~blank_active & (state==RUN).
  - dt_hit = i_dterr & ~i_dterr_mask & (state==RUN).
  - hit = mm_hit | dt_hit.
- Blanking:
  - An edge detector on i_pwm_in (registered copy) runs in every state.
  - Any edge loads blank_cnt = BLANK_CYC.
  - blank_cnt decrements to 0 and saturates there. blank_active = (blank_cnt != 0).
  - Counter width is $clog2(BLANK_CYC+1).
  - An edge arriving while blanking is active reloads the counter (retrigger).
- FSM:
  - IDLE -> RUN when i_pwm_en = 1.
  - RUN -> FAULT on hit, which takes priority over en.
  - RUN -> IDLE when i_pwm_en = 0 and there is no hit.
  - FAULT -> REARM on i_fault_clr, but only if no hit source is asserted that cycle. i_pwm_en is ignored in FAULT.
  - REARM:
    - Loads rearm_cnt = REARM_CYC - 1 on entry and counts down.
    - At 0, goes to RUN if i_pwm_en = 1, else IDLE.
    - If i_mmerr & ~mask or i_dterr & ~mask occurs during REARM (unblanked), it returns to FAULT and sets status.
- Status:
  - o_mmerr_sts / o_dterr_sts are set on the corresponding hit, or on the REARM-time error.
  - Both are cleared by i_fault_clr.
  - If set and clear land in the same cycle, set wins.
- o_pwm_out:
  - Combinational: i_pwm_in & (state==RUN) & ~hit.
  - The kill takes effect in the same cycle the error is accepted.

## Timing
- Error accepted in cycle N:
  - o_pwm_out = 0 in cycle N.
  - o_state = FAULT, status bit = 1 and o_fault_int = 1 from cycle N+1.
- i_fault_clr in cycle N (FAULT):
  - Status = 0 and state = REARM from N+1.
  - o_pwm_out stays 0 through cycle N+REARM_CYC.
  - RUN (if enabled) from N+REARM_CYC+1.
- i_pwm_en rise in cycle N (IDLE): RUN at N+1. i_pwm_in passes from N+1.
- i_pwm_en fall in RUN at cycle N: IDLE and o_pwm_out = 0 from N+1.
- Mid-operation reset forces every output to its reset value immediately (asynchronous), including during FAULT or REARM.
- Masks are sampled combinationally every cycle. Unmasking while i_mmerr is high and blanking is inactive causes a fault in that same cycle.

## Test plan
- Reset, en=1, toggle i_pwm_in with a 100-cycle period and no errors -> o_state=1 from the cycle after en, o_pwm_out == i_pwm_in, all status bits 0.
- In RUN, assert i_mmerr 10 cycles after an edge (BLANK_CYC=48) -> no fault, pwm passes. Assert i_mmerr 60 cycles after the edge -> o_pwm_out=0 that cycle, o_state=2, o_mmerr_sts=1, o_fault_int=1 on the next cycle.
- In RUN, 1-cycle i_dterr with i_dterr_mask=1 -> no effect. Same pulse with mask=0 -> FAULT, o_dterr_sts=1, o_mmerr_sts=0.
- In FAULT, pulse i_fault_clr with REARM_CYC=480, en=1 -> status cleared the next cycle, o_state=3 for 480 cycles with o_pwm_out=0, then o_state=1.
- In FAULT, pulse i_fault_clr in the same cycle as an unmasked i_dterr -> remains in FAULT, o_dterr_sts stays 1. Repeat with i_dterr 100 cycles into REARM -> back to FAULT, status=1.
- Assert i_rst_n=0 mid-REARM, then release with en=1 -> all outputs 0 during reset, o_state=0 then 1, no stale status.
